// File: rtl/sha3_224_padder.sv
// -----------------------------------------------------------------------------
// sha3_224_padder
//
// Collects 64-bit little-endian message words into a Keccak rate block and
// applies SHA-3 multi-rate padding (domain byte, zero fill, final 0x80) before
// handing each block to a downstream Keccak core.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   Reset      : synchronous, active-low reset
//   in_data    : message word, byte i in bits [8i+7:8i]
//   in_valid   : qualifies in_data
//   in_last    : marks the final word of a message
//   in_nbytes  : valid byte count (0..8) of the final word; 9..15 count as 8
//   in_ready   : word accepted when in_valid && in_ready
//   blk_data   : padded rate block, lane k in bits [64k+63:64k]
//   blk_valid  : qualifies blk_data
//   blk_last   : marks the final block of a message
//   blk_ready  : downstream takes the block when blk_valid && blk_ready
//
// Build option
//   SHA3_PAD_LEGACY_EN : when defined, uses the original Keccak domain byte
//                        0x01 instead of the SHA-3 domain byte 0x06.
// -----------------------------------------------------------------------------
module sha3_224_padder #(
    parameter int RATE_WORDS = 18
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [63:0]             in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [3:0]              in_nbytes,
    output logic                    in_ready,
    output logic [64*RATE_WORDS-1:0] blk_data,
    output logic                    blk_valid,
    output logic                    blk_last,
    input  logic                    blk_ready
);

    localparam int BLK_W  = 64 * RATE_WORDS;
    localparam int WCNT_W = $clog2(RATE_WORDS + 1);

`ifdef SHA3_PAD_LEGACY_EN
    localparam logic [7:0] DOMAIN = 8'h01;
`else
    localparam logic [7:0] DOMAIN = 8'h06;
`endif

    typedef enum logic [1:0] {
        ABSORB = 2'd0,
        EMIT   = 2'd1,
        PADBLK = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
    logic               pad_pend, pad_pend_nxt;
    logic               last_q, last_nxt;
    logic [BLK_W-1:0]   blk_buf, buf_nxt;
    int                 w_i;
    int                 nb_i;

    // Byte count of the final word, with out-of-range codes treated as a full word.
    function automatic int clamp_nbytes(input logic [3:0] nb);
        return (nb > 4'd8) ? 8 : int'(nb);
    endfunction

    // Keep the low nb bytes of a word and zero the rest.
    function automatic logic [63:0] keep_bytes(input logic [63:0] w, input int nb);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < nb) r[8*b +: 8] = w[8*b +: 8];
        end
        return r;
    endfunction

    // Block consisting of padding only: used when a message filled its last
    // block exactly and the padding spills into a fresh block.
    function automatic logic [BLK_W-1:0] pad_only_block();
        logic [BLK_W-1:0] r;
        r             = '0;
        r[7:0]        = DOMAIN;
        r[BLK_W-8 +: 8] = r[BLK_W-8 +: 8] ^ 8'h80;
        return r;
    endfunction

    always_comb begin
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        pad_pend_nxt = pad_pend;
        last_nxt     = last_q;
        buf_nxt      = blk_buf;
        in_ready     = 1'b0;
        blk_valid    = 1'b0;
        w_i          = int'(wcnt);
        nb_i         = clamp_nbytes(in_nbytes);

        case (state)
            ABSORB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!in_last) begin
                        buf_nxt[64*w_i +: 64] = in_data;
                        if (w_i == RATE_WORDS - 1) begin
                            state_nxt = EMIT;
                            last_nxt  = 1'b0;
                            wcnt_nxt  = '0;
                        end else begin
                            wcnt_nxt = wcnt + WCNT_W'(1);
                        end
                    end else begin
                        // Final word: keep its valid bytes, clear everything above.
                        for (int k = 0; k < RATE_WORDS; k++) begin
                            if (k == w_i)
                                buf_nxt[64*k +: 64] = keep_bytes(in_data, nb_i);
                            else if (k > w_i)
                                buf_nxt[64*k +: 64] = '0;
                        end
                        state_nxt = EMIT;
                        wcnt_nxt  = '0;
                        if (nb_i < 8 || w_i < RATE_WORDS - 1) begin
                            // XOR so the domain and 0x80 bytes merge when they
                            // land on the same final byte.
                            buf_nxt[8*(8*w_i + nb_i) +: 8] = buf_nxt[8*(8*w_i + nb_i) +: 8] ^ DOMAIN;
                            buf_nxt[BLK_W-8 +: 8]          = buf_nxt[BLK_W-8 +: 8] ^ 8'h80;
                            last_nxt = 1'b1;
                        end else begin
                            // Block is full of data; padding goes in an extra block.
                            last_nxt     = 1'b0;
                            pad_pend_nxt = 1'b1;
                        end
                    end
                end
            end

            EMIT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    if (pad_pend) begin
                        state_nxt = PADBLK;
                    end else begin
                        state_nxt = ABSORB;
                        wcnt_nxt  = '0;
                        buf_nxt   = '0;
                    end
                end
            end

            PADBLK: begin
                buf_nxt      = pad_only_block();
                pad_pend_nxt = 1'b0;
                last_nxt     = 1'b1;
                state_nxt    = EMIT;
            end

            default: begin
                state_nxt = ABSORB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state    <= ABSORB;
            wcnt     <= '0;
            pad_pend <= 1'b0;
            last_q   <= 1'b0;
            blk_buf  <= '0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            pad_pend <= pad_pend_nxt;
            last_q   <= last_nxt;
            blk_buf  <= buf_nxt;
        end
    end

    assign blk_data = blk_buf;
    assign blk_last = last_q;

endmodule

// File: tb/tb_sha3_224_padder.sv
module tb_sha3_224_padder;

    localparam int R  = 18;
    localparam int NB = 8 * R;
    localparam int BW = 64 * R;

`ifdef SHA3_PAD_LEGACY_EN
    localparam logic [7:0] DOM = 8'h01;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic [63:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [3:0]    in_nbytes = '0;
    logic          in_ready;
    logic [BW-1:0] blk_data;
    logic          blk_valid;
    logic          blk_last;
    logic          blk_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0]    msg_q[$];
    logic [BW-1:0] exp_blk[$];
    bit            exp_last[$];
    logic [63:0]   w_data[$];
    logic [3:0]    w_nb[$];
    bit            w_last[$];

    sha3_224_padder #(.RATE_WORDS(R)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ready (blk_ready)
    );

    always #5 clk = ~clk;

    // Reference: message bytes, then domain byte, zero fill to a whole number
    // of rate blocks, then 0x80 XORed into the very last byte.
    function automatic void compute_expected();
        logic [7:0]    p[$];
        logic [BW-1:0] b;
        int            nblk;
        p = msg_q;
        p.push_back(DOM);
        while (p.size() % NB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        nblk = p.size() / NB;
        exp_blk.delete();
        exp_last.delete();
        for (int i = 0; i < nblk; i++) begin
            b = '0;
            for (int j = 0; j < NB; j++) b[8*j +: 8] = p[i*NB + j];
            exp_blk.push_back(b);
            exp_last.push_back(i == nblk - 1);
        end
    endfunction

    // Split the message into words; a length that is a multiple of 8 may end
    // either with a full last word or with an extra empty last word.
    function automatic void build_words(input bit empty_tail);
        int          L;
        int          idx;
        int          rem;
        logic [63:0] w;
        L = msg_q.size();
        w_data.delete(); w_nb.delete(); w_last.delete();
        idx = 0;
        while (idx + 8 < L || (idx + 8 == L && empty_tail)) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = msg_q[idx + b];
            w_data.push_back(w); w_nb.push_back(4'($urandom_range(0, 15))); w_last.push_back(1'b0);
            idx += 8;
        end
        rem = L - idx;
        w = {$urandom, $urandom};
        for (int b = 0; b < rem; b++) w[8*b +: 8] = msg_q[idx + b];
        w_data.push_back(w);
        w_nb.push_back((rem == 8) ? 4'($urandom_range(8, 15)) : 4'(rem));
        w_last.push_back(1'b1);
    endfunction

    function automatic int first_diff(input logic [BW-1:0] a, input logic [BW-1:0] b);
        for (int j = 0; j < NB; j++) if (a[8*j +: 8] !== b[8*j +: 8]) return j;
        return 0;
    endfunction

    task automatic run_msg(input string name);
        int            wi, bi, cyc, lane, d;
        bit            vld_due, stall, held_last;
        logic [BW-1:0] held;
        wi = 0; bi = 0; cyc = 0; lane = 0;
        vld_due = 0; stall = 0; held_last = 0; held = '0;
        compute_expected();
        build_words(1'($urandom_range(0, 1)));
        while ((wi < w_data.size() || bi < exp_blk.size()) && cyc < 3000) begin
            if (wi < w_data.size() && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = w_data[wi]; in_last = w_last[wi]; in_nbytes = w_nb[wi];
            end else begin
                in_valid = 1'b0; in_data = {$urandom, $urandom};
                in_last = 1'($urandom_range(0, 1)); in_nbytes = 4'($urandom_range(0, 15));
            end
            blk_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (vld_due) begin
                checks++;
                if (blk_valid !== 1'b1) begin
                    errors++; $display("FAIL %s latency: blk_valid=%b expected 1", name, blk_valid);
                end
            end
            vld_due = 0;
            if (stall) begin
                checks++;
                if (blk_valid !== 1'b1 || blk_data !== held || blk_last !== held_last) begin
                    errors++; $display("FAIL %s hold: blk_valid=%b blk_last=%b data_same=%b expected 1/%b/1",
                                       name, blk_valid, blk_last, blk_data === held, held_last);
                end
            end
            stall = 0;
            if (wi == w_data.size() && bi < exp_blk.size()) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL %s ready_block: in_ready=%b expected 0", name, in_ready);
                end
            end
            if (blk_valid === 1'b1) begin
                if (blk_ready) begin
                    checks++;
                    if (bi >= exp_blk.size()) begin
                        errors++; $display("FAIL %s extra_block: got block %0d expected only %0d", name, bi, exp_blk.size());
                    end else begin
                        if (blk_data !== exp_blk[bi]) begin
                            d = first_diff(blk_data, exp_blk[bi]);
                            errors++; $display("FAIL %s blk%0d data byte %0d: got %h expected %h",
                                               name, bi, d, blk_data[8*d +: 8], exp_blk[bi][8*d +: 8]);
                        end
                        checks++;
                        if (blk_last !== exp_last[bi]) begin
                            errors++; $display("FAIL %s blk%0d last: got %b expected %b", name, bi, blk_last, exp_last[bi]);
                        end
                    end
                    bi++;
                end else begin
                    stall = 1; held = blk_data; held_last = blk_last;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                if (w_last[wi] || lane == R - 1) begin vld_due = 1; lane = 0; end
                else lane++;
                wi++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        checks++;
        if (cyc >= 3000) begin
            errors++; $display("FAIL %s timeout: words %0d/%0d blocks %0d/%0d", name, wi, w_data.size(), bi, exp_blk.size());
        end
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s idle_after: blk_valid=%b in_ready=%b expected 0/1", name, blk_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    task automatic test_reset();
        Reset = 1'b0; in_valid = 1'b1; in_data = 64'h636261; in_last = 1'b1; in_nbytes = 4'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset blk_valid: got %b expected 0", blk_valid); end
        checks++;
        if (blk_last !== 1'b0) begin errors++; $display("FAIL reset blk_last: got %b expected 0", blk_last); end
        checks++;
        if (blk_data !== '0) begin errors++; $display("FAIL reset blk_data: nonzero, expected 0"); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        Reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: in_ready=%b blk_valid=%b expected 1/0", in_ready, blk_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        set_abc();
        run_msg("abc");
    endtask

    task automatic test_empty();
        msg_q.delete();
        run_msg("empty");
    endtask

    task automatic test_143();
        msg_q.delete();
        for (int i = 0; i < 143; i++) msg_q.push_back(8'($urandom));
        run_msg("len143");
    endtask

    task automatic test_144();
        msg_q.delete();
        for (int i = 0; i < 144; i++) msg_q.push_back(8'($urandom));
        run_msg("len144");
    endtask

    task automatic test_stall();
        logic [BW-1:0] held;
        held = '0;
        set_abc();
        compute_expected();
        in_valid = 1'b1; in_data = 64'h636261; in_last = 1'b1; in_nbytes = 4'd3; blk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall accept: in_ready=%b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                held = blk_data;
                checks++;
                if (held !== exp_blk[0] || blk_last !== 1'b1) begin
                    errors++; $display("FAIL stall abc_block: last=%b byte3=%h byte143=%h expected 1/%h/80",
                                       blk_last, held[31:24], held[BW-1 -: 8], DOM);
                end
                checks++;
                if (held[31:24] !== DOM || held[BW-1 -: 8] !== 8'h80 || held[23:0] !== 24'h636261) begin
                    errors++; $display("FAIL stall abc_bytes: byte0..3=%h byte143=%h expected %h636261/80",
                                       held[31:0], held[BW-1 -: 8], DOM);
                end
            end
            checks++;
            if (blk_valid !== 1'b1 || blk_data !== held || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall cycle%0d: blk_valid=%b stable=%b in_ready=%b expected 1/1/0",
                                   c, blk_valid, blk_data === held, in_ready);
            end
            @(posedge clk); #1;
        end
        blk_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== held) begin
            errors++; $display("FAIL stall handshake: blk_valid=%b stable=%b expected 1/1", blk_valid, blk_data === held);
        end
        @(posedge clk); #1;
        blk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall after: blk_valid=%b in_ready=%b expected 0/1", blk_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_last = 1'b0; blk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_data = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL mid word%0d: in_ready=%b expected 1", c, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; Reset = 1'b0;
        @(posedge clk); #1;
        Reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_data !== '0) begin
            errors++; $display("FAIL mid reset: in_ready=%b blk_valid=%b data_zero=%b expected 1/0/1",
                               in_ready, blk_valid, blk_data === '0);
        end
        @(posedge clk); #1;
        set_abc();
        run_msg("abc_after_reset");
    endtask

    task automatic test_reset_emit();
        in_valid = 1'b1; in_data = 64'h636261; in_last = 1'b1; in_nbytes = 4'd3; blk_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b1) begin errors++; $display("FAIL emit_reset pre: blk_valid=%b expected 1", blk_valid); end
        @(posedge clk); #1;
        Reset = 1'b0;
        @(posedge clk); #1;
        Reset = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL emit_reset post: blk_valid=%b in_ready=%b expected 0/1", blk_valid, in_ready);
        end
        @(posedge clk); #1;
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
        run_msg("len20_after_emit_reset");
    endtask

    task automatic test_random();
        int lens[6] = '{135, 136, 287, 288, 8, 7};
        int L;
        for (int m = 0; m < 24; m++) begin
            L = (m < 6) ? lens[m] : int'($urandom_range(0, 320));
            msg_q.delete();
            for (int i = 0; i < L; i++) msg_q.push_back(8'($urandom));
            run_msg($sformatf("rand%0d_len%0d", m, L));
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_143();
        test_144();
        test_stall();
        test_reset_mid();
        test_reset_emit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_224_padder.md
SHA3_224_PADDER -- requirements
Module: sha3_224_padder

Interface
REQ-001 The block SHALL have parameter RATE_WORDS, default 18, giving the 64-bit lanes per rate block (18 lanes = 1152 bits for SHA3-224).
REQ-002 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port in_data, input, 64, the message word; byte i is in bits [8i+7:8i] (little-endian).
REQ-005 The block SHALL have port in_valid, input, 1, qualifying in_data.
REQ-006 The block SHALL have port in_last, input, 1, marking the final word of a message.
REQ-007 The block SHALL have port in_nbytes, input, 4, the valid byte count (0..8) of a word with in_last high, ignored otherwise; values 9..15 count as 8.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the word is accepted when in_valid and in_ready are both high.
REQ-009 The block SHALL have port blk_data, output, 64*RATE_WORDS, the padded rate block; lane k is bits [64k+63:64k].
REQ-010 The block SHALL have port blk_valid, output, 1, qualifying blk_data.
REQ-011 The block SHALL have port blk_last, output, 1, marking the final block of a message.
REQ-012 The block SHALL have port blk_ready, input, 1, meaning the downstream Keccak core takes the block when blk_valid and blk_ready are both high.

Function
REQ-013 The block SHALL implement states ABSORB, EMIT and PADBLK.
REQ-014 In ABSORB, each accepted word SHALL be written to lane wcnt and wcnt SHALL increment.
REQ-015 An accepted non-last word with wcnt==RATE_WORDS-1 SHALL move the block to EMIT with blk_last=0.
REQ-016 An accepted last word SHALL keep its in_nbytes bytes and zero the rest of the lane and all higher lanes.
REQ-017 When the last word has in_nbytes<8, or when in_nbytes==8 with wcnt<RATE_WORDS-1, the block SHALL XOR the domain byte into the first free byte and XOR 0x80 into byte 8*RATE_WORDS-1.
REQ-018 REQ-017 SHALL go to EMIT with blk_last=1 in the cycle after acceptance.
REQ-019 If the pad byte and the final byte coincide (byte 143), that byte SHALL read 0x86.
REQ-020 A last word with in_nbytes==8 at wcnt==RATE_WORDS-1 SHALL go to EMIT with blk_last=0 and with the pad-pending flag set.
REQ-021 In EMIT, blk_valid SHALL be 1 and blk_data and blk_last SHALL hold stable until blk_ready.
REQ-022 On handshake from EMIT, the block SHALL go to PADBLK if pad-pending is set, else to ABSORB with wcnt=0 and the buffer cleared.
REQ-023 PADBLK SHALL last one cycle: buffer = domain byte at byte 0, 0x80 at the last byte, zeros elsewhere; pad-pending cleared; then EMIT with blk_last=1.
REQ-024 in_ready SHALL be 1 only in ABSORB, and no word SHALL be accepted in EMIT or PADBLK.
REQ-025 in_valid low in ABSORB SHALL hold all state.
REQ-026 The domain byte SHALL be 0x06 (SHA-3).
REQ-027 Latency from last-word acceptance to blk_valid SHALL be 1 cycle; a full block SHALL also appear 1 cycle after its final word.

Reset
REQ-028 While Reset==0 at a clock edge, the block SHALL set: state=ABSORB, wcnt=0, pad-pending=0, buffer=0.
REQ-029 Under the same reset, outputs SHALL be blk_valid=0, blk_last=0, blk_data=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-030 Reset mid-message or mid-EMIT SHALL discard the partial message and any pending block without emitting it.

Configuration
REQ-031 With macro SHA3_PAD_LEGACY_EN defined, the domain byte SHALL be 0x01 (original Keccak padding; the coincident byte reads 0x81).
REQ-032 Without SHA3_PAD_LEGACY_EN, the domain byte SHALL be 0x06, and all else is identical.

Verification
REQ-033 "abc": in_data=64'h636261, in_nbytes=3, in_last -> one block: bytes 0..2=61 62 63, byte3=06, byte143=80, others 0, blk_last=1.
REQ-034 Empty message: in_nbytes=0, in_last at wcnt 0 -> byte0=06, byte143=80, rest 0, blk_last=1.
REQ-035 143-byte message (17 full words + last nbytes=7) -> single block with byte143=86, blk_last=1.
REQ-036 144-byte message -> block 1 has data only and blk_last=0; block 2 has byte0=06, byte143=80 and blk_last=1; in_ready=0 until block 2 is taken.
REQ-037 blk_ready held low 5 cycles in EMIT -> blk_data and blk_valid stable and in_ready=0 throughout; handshake on the 6th cycle.
REQ-038 Reset=0 after 5 words accepted -> next cycle in_ready=1 and blk_valid=0; a following "abc" yields exactly the block of REQ-033.
REQ-039 With SHA3_PAD_LEGACY_EN defined, the "abc" stimulus -> byte3=01.
